// File: rtl/mem_line_responder.sv
// Main-memory responder behind the I- and D-cache line-fill/write-back ports.
// Serves one full-line request at a time after a fixed latency, arbitrating round-robin.
module mem_line_responder #(
    parameter int CACHE_LINE_SIZE = 128,
    parameter int MEM_LINES       = 1024,
    parameter int MEM_LATENCY     = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_i_read_en,
    input  logic [31:0]                in_i_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
    output logic                       out_i_ready,
    input  logic                       in_d_read_en,
    input  logic                       in_d_write_en,
    input  logic [31:0]                in_d_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
    output logic                       out_d_ready,
    output logic                       out_busy
);
    localparam int OFF   = $clog2(CACHE_LINE_SIZE / 8);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic [1:0]                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       last_grant_q, last_grant_d;
    logic                       port_q, port_d;
    logic                       wr_q, wr_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
    logic [CACHE_LINE_SIZE-1:0] i_rdata_q, d_rdata_q;
    logic [CACHE_LINE_SIZE-1:0] mem_q [MEM_LINES];

    logic d_req;
    logic grant_port;
    logic commit;
    logic unused_addr_bits;

    assign d_req            = in_d_read_en | in_d_write_en;
    assign commit           = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
    assign unused_addr_bits = ^{in_i_addr, in_d_addr};

    // On a tie the port that did not win last time is granted.
    always_comb begin
        if (in_i_read_en && d_req) begin
            grant_port = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
        end else begin
            grant_port = d_req ? PORT_D : PORT_I;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (in_i_read_en || d_req) begin
                    state_d      = ST_BUSY;
                    cnt_d        = CNT_W'(MEM_LATENCY - 1);
                    last_grant_d = grant_port;
                    port_d       = grant_port;
                    // A D request with both enables high is a write; the read is dropped.
                    wr_d         = (grant_port == PORT_D) && in_d_write_en;
                    idx_d        = (grant_port == PORT_D) ? in_d_addr[OFF +: IDX_W]
                                                          : in_i_addr[OFF +: IDX_W];
                    wdata_d      = in_d_write_data;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_I;
            port_q       <= PORT_I;
            wr_q         <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            wr_q         <= wr_d;
            if (commit && !wr_q) begin
                if (port_q == PORT_D) begin
                    d_rdata_q <= mem_q[idx_q];
                end else begin
                    i_rdata_q <= mem_q[idx_q];
                end
            end
        end
    end

    // Request payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (commit && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign out_i_read_data = i_rdata_q;
    assign out_d_read_data = d_rdata_q;
    assign out_i_ready     = (state_q == ST_RESP) && (port_q == PORT_I);
    assign out_d_ready     = (state_q == ST_RESP) && (port_q == PORT_D);
    assign out_busy        = (state_q != ST_IDLE);

endmodule
